// File: rtl/alu_ctrl_issue_pkg.sv
// Shared ALU control encodings: per-slice operation codes, main-control ALUOp codes
// and R-type funct codes used by the issue stage and the ALU datapath.
package alu_ctrl_issue_pkg;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_oper_e;

   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_BEQ   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [5:0] FUNCT_ADD = 6'd32;
   localparam logic [5:0] FUNCT_SUB = 6'd34;
   localparam logic [5:0] FUNCT_AND = 6'd36;
   localparam logic [5:0] FUNCT_OR  = 6'd37;
   localparam logic [5:0] FUNCT_SLT = 6'd42;

   // SUB and SLT are the only codes with bit 2 set; that bit inverts B and feeds slice-0 carry.
   function automatic logic binvt_of(input alu_oper_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/alu_ctrl_issue_if.sv
// ID->EX issue bundle: instruction-side valid/ready with operands, EX-side valid/ready
// with decoded slice controls. slave = the issue stage, master = its environment.
interface alu_ctrl_issue_if #(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_alu_op;
   logic [5:0]    in_funct;
   logic [DW-1:0] in_opa;
   logic [DW-1:0] in_opb;
   logic [RW-1:0] in_rd;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    ALUOperation;
   logic          bInvt;
   logic          cin0;
   logic [DW-1:0] out_opa;
   logic [DW-1:0] out_opb;
   logic [RW-1:0] out_rd;
   logic          illegal;

   modport slave (
      input  in_valid, in_alu_op, in_funct, in_opa, in_opb, in_rd, out_ready,
      output in_ready, out_valid, ALUOperation, bInvt, cin0, out_opa, out_opb, out_rd, illegal
   );

   modport master (
      output in_valid, in_alu_op, in_funct, in_opa, in_opb, in_rd, out_ready,
      input  in_ready, out_valid, ALUOperation, bInvt, cin0, out_opa, out_opb, out_rd, illegal
   );
endinterface

// File: rtl/alu_ctrl_issue_decode.sv
// Combinational ALU control decode: main-control ALUOp plus R-type funct to slice controls.
// Undecodable combinations fall back to ADD and raise illegal.
module alu_ctrl_issue_decode
   import alu_ctrl_issue_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   output alu_oper_e  alu_operation_o,
   output logic       b_invt_o,
   output logic       illegal_o
);

   always_comb begin
      alu_operation_o = ALU_ADD;
      illegal_o       = 1'b0;
      case (alu_op_i)
         ALUOP_MEM: alu_operation_o = ALU_ADD;
         ALUOP_BEQ: alu_operation_o = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct_i)
               FUNCT_ADD: alu_operation_o = ALU_ADD;
               FUNCT_SUB: alu_operation_o = ALU_SUB;
               FUNCT_AND: alu_operation_o = ALU_AND;
               FUNCT_OR:  alu_operation_o = ALU_OR;
               FUNCT_SLT: alu_operation_o = ALU_SLT;
               default:   illegal_o       = 1'b1;
            endcase
         end
         default: illegal_o = 1'b1;
      endcase
   end

   assign b_invt_o = binvt_of(alu_operation_o);

endmodule

// File: rtl/alu_ctrl_issue.sv
// ID->EX issue stage: decodes ALU control and holds it with operands in a two-entry
// skid pipeline so in_ready is register-derived and EX stalls never reach ID combinationally.
module alu_ctrl_issue
   import alu_ctrl_issue_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   alu_ctrl_issue_if.slave   bus
);

   typedef struct packed {
      alu_oper_e     op;
      logic          binvt;
      logic          illegal;
      logic [DW-1:0] opa;
      logic [DW-1:0] opb;
      logic [RW-1:0] rd;
   } entry_t;

   alu_oper_e dec_op;
   logic      dec_binvt;
   logic      dec_ill;
   entry_t    in_entry;
   entry_t    main_q, main_d, skid_q, skid_d;
   logic      main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic      accept, consume;

   alu_ctrl_issue_decode u_decode (
      .alu_op_i        (bus.in_alu_op),
      .funct_i         (bus.in_funct),
      .alu_operation_o (dec_op),
      .b_invt_o        (dec_binvt),
      .illegal_o       (dec_ill)
   );

   assign in_entry = '{op: dec_op, binvt: dec_binvt, illegal: dec_ill,
                       opa: bus.in_opa, opb: bus.in_opb, rd: bus.in_rd};

   assign accept  = bus.in_valid & ~skid_vld_q & ~flush;
   assign consume = main_vld_q & bus.out_ready;

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!main_vld_q || consume) begin
         // Skid can only be full while main is full, so draining skid excludes a new accept.
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            main_d     = in_entry;
            main_vld_d = 1'b1;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = in_entry;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign bus.in_ready     = ~skid_vld_q;
   assign bus.out_valid    = main_vld_q;
   assign bus.ALUOperation = main_q.op;
   assign bus.bInvt        = main_q.binvt;
   assign bus.cin0         = main_q.binvt;
   assign bus.illegal      = main_q.illegal;
   assign bus.out_opa      = main_q.opa;
   assign bus.out_opb      = main_q.opb;
   assign bus.out_rd       = main_q.rd;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Scoreboard bench for alu_ctrl_issue: directed decode, back-pressure, flush and reset
// vectors plus a random-ready stream; a negedge monitor checks every delivered entry.
module tb_alu_ctrl_issue;
   import alu_ctrl_issue_pkg::*;

   localparam int DW = 32;
   localparam int RW = 5;

   typedef struct packed {
      logic [2:0]    op;
      logic          ill;
      logic [DW-1:0] opa;
      logic [DW-1:0] opb;
      logic [RW-1:0] rd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic rand_en = 1'b0;
   logic or_rand = 1'b0;
   logic or_manual = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic armed = 1'b0;
   logic stall_prev = 1'b0;
   exp_t pend, snap, got_m, exp_m;
   exp_t q[$];
   logic [5:0] ftab [8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd8, 6'd63};

   always #5 clk = ~clk;

   alu_ctrl_issue_if #(.DW(DW), .RW(RW)) bus ();

   alu_ctrl_issue #(.DW(DW), .RW(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   assign bus.out_ready = rand_en ? or_rand : or_manual;

   always @(posedge clk) begin
      #1 or_rand = 1'($urandom_range(0, 1));
   end

   // Independent reference decode: returns {illegal, ALUOperation}.
   function automatic logic [3:0] model(input logic [1:0] aop, input logic [5:0] f);
      case (aop)
         2'd0: return {1'b0, 3'b010};
         2'd1: return {1'b0, 3'b110};
         2'd2: begin
            case (f)
               6'd32:   return {1'b0, 3'b010};
               6'd34:   return {1'b0, 3'b110};
               6'd36:   return {1'b0, 3'b000};
               6'd37:   return {1'b0, 3'b001};
               6'd42:   return {1'b0, 3'b111};
               default: return {1'b1, 3'b010};
            endcase
         end
         default: return {1'b1, 3'b010};
      endcase
   endfunction

   always @(negedge clk) begin
      got_m = {bus.ALUOperation, bus.illegal, bus.out_opa, bus.out_opb, bus.out_rd};
      if (armed && rst_n) begin
         checks++;
         if (bus.in_ready !== (q.size() < 2)) begin
            errors++;
            $display("FAIL in_ready_occ: got %b want %b (held=%0d)", bus.in_ready, (q.size() < 2), q.size());
         end
         checks++;
         if (bus.out_valid !== (q.size() > 0)) begin
            errors++;
            $display("FAIL out_valid_occ: got %b want %b (held=%0d)", bus.out_valid, (q.size() > 0), q.size());
         end
         if (stall_prev && bus.out_valid) begin
            checks++;
            if (got_m !== snap) begin
               errors++;
               $display("FAIL stall_stable: got %h want %h", got_m, snap);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL underflow: DUT delivered %h with nothing expected", got_m);
            end else begin
               exp_m = q.pop_front();
               if ({got_m, bus.bInvt, bus.cin0} !== {exp_m, exp_m.op[2], exp_m.op[2]}) begin
                  errors++;
                  $display("FAIL entry: got op=%b binv=%b cin=%b ill=%b a=%h b=%h rd=%0d want op=%b binv=%b cin=%b ill=%b a=%h b=%h rd=%0d",
                           got_m.op, bus.bInvt, bus.cin0, got_m.ill, got_m.opa, got_m.opb, got_m.rd,
                           exp_m.op, exp_m.op[2], exp_m.op[2], exp_m.ill, exp_m.opa, exp_m.opb, exp_m.rd);
               end
            end
         end
      end
      stall_prev = armed && rst_n && !flush && bus.out_valid && !bus.out_ready;
      snap = got_m;
      if (!rst_n) armed = 1'b1;
      if (!rst_n || flush) q.delete();
      if (armed && rst_n && !flush && bus.in_valid && bus.in_ready) q.push_back(pend);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] aop, input logic [5:0] f, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [RW-1:0] rd,
                       input logic [2:0] eop, input logic eill);
      int t;
      bus.in_alu_op = aop;
      bus.in_funct  = f;
      bus.in_opa    = a;
      bus.in_opb    = b;
      bus.in_rd     = rd;
      pend          = {eop, eill, a, b, rd};
      bus.in_valid  = 1'b1;
      t = 0;
      while (!bus.in_ready && t < 200) begin
         cyc(1);
         t++;
      end
      if (t >= 200) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready got 0 want 1 within 200 cycles");
      end
      cyc(1);
      bus.in_valid = 1'b0;
   endtask

   initial begin
      logic [1:0]    aop;
      logic [5:0]    f;
      logic [3:0]    m;
      int            t;
      bus.in_valid  = 1'b1;
      bus.in_alu_op = 2'b10;
      bus.in_funct  = 6'd34;
      bus.in_opa    = 32'hdead_beef;
      bus.in_opb    = 32'h1234_5678;
      bus.in_rd     = 5'd9;
      pend          = '0;

      // Reset held two cycles with in_valid asserted
      rst_n = 1'b0;
      cyc(2);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_aluop", 32'(bus.ALUOperation), 32'd0);
      chk("rst_binvt_cin", 32'({bus.bInvt, bus.cin0, bus.illegal}), 32'd0);
      chk("rst_opa", bus.out_opa, 32'd0);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Decode sweep at full throughput
      or_manual = 1'b1;
      send(2'b10, 6'd32, 32'd11, 32'd1, 5'd1, 3'b010, 1'b0);
      send(2'b10, 6'd34, 32'd12, 32'd2, 5'd2, 3'b110, 1'b0);
      send(2'b10, 6'd36, 32'd13, 32'd3, 5'd3, 3'b000, 1'b0);
      send(2'b10, 6'd37, 32'd14, 32'd4, 5'd4, 3'b001, 1'b0);
      send(2'b10, 6'd42, 32'd15, 32'd5, 5'd5, 3'b111, 1'b0);
      send(2'b10, 6'h08, 32'd16, 32'd6, 5'd6, 3'b010, 1'b1);
      send(2'b01, 6'd37, 32'd17, 32'd7, 5'd7, 3'b110, 1'b0);
      send(2'b00, 6'd34, 32'd18, 32'd8, 5'd8, 3'b010, 1'b0);
      send(2'b11, 6'd32, 32'd19, 32'd9, 5'd9, 3'b010, 1'b1);
      cyc(3);

      // Back-pressure fills main then skid
      or_manual = 1'b0;
      send(2'b00, 6'd0, 32'd5, 32'd50, 5'd10, 3'b010, 1'b0);
      send(2'b01, 6'd0, 32'd7, 32'd70, 5'd11, 3'b110, 1'b0);
      chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      chk("bp_opa_hold", bus.out_opa, 32'd5);
      cyc(3);
      chk("bp_opa_still", bus.out_opa, 32'd5);
      or_manual = 1'b1;
      cyc(1);
      chk("bp_second_opa", bus.out_opa, 32'd7);
      chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
      cyc(1);
      chk("bp_drained", 32'(bus.out_valid), 32'd0);

      // Flush with both entries held and a new instruction offered
      or_manual = 1'b0;
      send(2'b10, 6'd36, 32'd100, 32'd1, 5'd12, 3'b000, 1'b0);
      send(2'b10, 6'd37, 32'd101, 32'd2, 5'd13, 3'b001, 1'b0);
      bus.in_alu_op = 2'b10;
      bus.in_funct  = 6'd42;
      bus.in_opa    = 32'hC0C0_C0C0;
      pend          = {3'b111, 1'b0, 32'hC0C0_C0C0, bus.in_opb, bus.in_rd};
      bus.in_valid  = 1'b1;
      flush         = 1'b1;
      cyc(1);
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
      or_manual = 1'b1;
      cyc(3);
      chk("flush_no_c", 32'(bus.out_valid), 32'd0);

      // Random stream under random EX back-pressure
      rand_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         aop = 2'($urandom_range(0, 3));
         f   = ftab[$urandom_range(0, 7)];
         m   = model(aop, f);
         send(aop, f, $urandom, $urandom, 5'($urandom_range(0, 31)), m[2:0], m[3]);
      end
      rand_en = 1'b0;
      t = 0;
      while (q.size() > 0 && t < 100) begin
         cyc(1);
         t++;
      end
      chk("stream_drained", 32'(q.size()), 32'd0);
      cyc(1);

      // Reset while both entries are held
      or_manual = 1'b0;
      send(2'b00, 6'd0, 32'd21, 32'd1, 5'd14, 3'b010, 1'b0);
      send(2'b01, 6'd0, 32'd22, 32'd2, 5'd15, 3'b110, 1'b0);
      bus.in_valid = 1'b1;
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      or_manual = 1'b1;
      cyc(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
